// File: rtl/mtsp_alu_writeback.sv
// mtsp_alu_writeback: MTSP ALU write-back stage with issue delay line, pending-write scoreboard and RF write port
// Ports:
//   clk_i, rst_i (async, active-high)
//   issue_en_i/issue_addr_i  : SM-stage issue of a register-targeting instruction
//   flush_i                  : kill all in-flight write-backs
//   wmask_i/dest_i           : ALU EX2 result (wmask_i active-low write)
//   qa/qb_addr_i, qa/qb_busy_o : SM hazard query
//   fwd_addr_i, fwd_hit_o, fwd_data_o : forwarding of the write on rf_*
//   rf_we_o/rf_waddr_o/rf_wdata_o : registered register-file write port
//   err_orphan_o             : sticky, ALU wrote with no matching issued slot
// Optional feature macro: MTSP_WB_FORWARD_EN (forwarding instead of one extra busy cycle)
module mtsp_alu_writeback #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    parameter int LAT    = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              issue_en_i,
    input  logic [ADDR_W-1:0] issue_addr_i,
    input  logic              flush_i,
    input  logic              wmask_i,
    input  logic [DATA_W-1:0] dest_i,
    input  logic [ADDR_W-1:0] qa_addr_i,
    input  logic [ADDR_W-1:0] qb_addr_i,
    output logic              qa_busy_o,
    output logic              qb_busy_o,
    input  logic [ADDR_W-1:0] fwd_addr_i,
    output logic              fwd_hit_o,
    output logic [DATA_W-1:0] fwd_data_o,
    output logic              rf_we_o,
    output logic [ADDR_W-1:0] rf_waddr_o,
    output logic [DATA_W-1:0] rf_wdata_o,
    output logic              err_orphan_o
);
    logic [LAT-1:0]    vld_q, vld_d;
    logic [ADDR_W-1:0] addr_q [LAT];
    logic [ADDR_W-1:0] addr_d [LAT];
    logic [2:0]        shd_q, shd_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic              rf_busy_a, rf_busy_b;
    always_comb begin
        vld_d[0]  = issue_en_i & ~flush_i;
        addr_d[0] = issue_addr_i;
        for (int k = 1; k < LAT; k++) begin
            vld_d[k]  = vld_q[k-1] & ~flush_i;
            addr_d[k] = addr_q[k-1];
        end
        we_d    = vld_q[LAT-1] & ~wmask_i & ~flush_i;
        waddr_d = we_d ? addr_q[LAT-1] : waddr_q;
        wdata_d = we_d ? dest_i : wdata_q;
        // Shadow window lets the ALU drain flushed ops without tripping the orphan check
        shd_d   = flush_i ? 3'(LAT) : (shd_q != 3'd0 ? shd_q - 3'd1 : shd_q);
        err_d   = err_q | (~wmask_i & ~vld_q[LAT-1] & (shd_q == 3'd0));
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q   <= '0;
            addr_q  <= '{default: '0};
            shd_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            vld_q   <= vld_d;
            addr_q  <= addr_d;
            shd_q   <= shd_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end
`ifdef MTSP_WB_FORWARD_EN
    assign fwd_hit_o  = we_q & (waddr_q == fwd_addr_i);
    assign fwd_data_o = fwd_hit_o ? wdata_q : '0;
    assign rf_busy_a  = 1'b0;
    assign rf_busy_b  = 1'b0;
`else
    logic unused_fwd;
    assign unused_fwd = ^fwd_addr_i;
    assign fwd_hit_o  = 1'b0;
    assign fwd_data_o = '0;
    // Without forwarding the register stays busy while its write sits on the RF port
    assign rf_busy_a  = we_q & (waddr_q == qa_addr_i);
    assign rf_busy_b  = we_q & (waddr_q == qb_addr_i);
`endif
    always_comb begin
        qa_busy_o = rf_busy_a;
        qb_busy_o = rf_busy_b;
        for (int k = 0; k < LAT; k++) begin
            qa_busy_o = qa_busy_o | (vld_q[k] & (addr_q[k] == qa_addr_i));
            qb_busy_o = qb_busy_o | (vld_q[k] & (addr_q[k] == qb_addr_i));
        end
    end
    assign rf_we_o      = we_q;
    assign rf_waddr_o   = waddr_q;
    assign rf_wdata_o   = wdata_q;
    assign err_orphan_o = err_q;
endmodule

// File: tb/tb_mtsp_alu_writeback.sv
// tb_mtsp_alu_writeback: table-driven cycle vectors plus write scoreboard for mtsp_alu_writeback
module tb_mtsp_alu_writeback;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue_en = 1'b0;
    logic [5:0]  issue_addr = '0;
    logic        flush = 1'b0;
    logic        wmask = 1'b1;
    logic [31:0] dest = '0;
    logic [5:0]  qa_addr = '0, qb_addr = '0, fwd_addr = '0;
    logic        qa_busy, qb_busy, fwd_hit, rf_we, err_orphan;
    logic [31:0] fwd_data, rf_wdata;
    logic [5:0]  rf_waddr;

    mtsp_alu_writeback dut (
        .clk_i(clk), .rst_i(rst), .issue_en_i(issue_en), .issue_addr_i(issue_addr),
        .flush_i(flush), .wmask_i(wmask), .dest_i(dest),
        .qa_addr_i(qa_addr), .qb_addr_i(qb_addr), .qa_busy_o(qa_busy), .qb_busy_o(qb_busy),
        .fwd_addr_i(fwd_addr), .fwd_hit_o(fwd_hit), .fwd_data_o(fwd_data),
        .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata), .err_orphan_o(err_orphan)
    );

    always #5 clk = ~clk;

`ifdef MTSP_WB_FORWARD_EN
    localparam bit RFB = 1'b0;
`else
    localparam bit RFB = 1'b1;
`endif

    typedef struct {
        logic rst, ie;
        logic [5:0] ia;
        logic fl, wm;
        logic [31:0] d;
        logic [5:0] qa, qb;
        logic push;
        logic [5:0] pa;
        logic e_we, e_qa, e_qb, e_err;
    } vec_t;
    typedef struct {
        logic [5:0]  a;
        logic [31:0] d;
    } wr_t;

    vec_t tbl[$];
    wr_t  sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   row = -1;

    function automatic vec_t v(logic r, logic ie, logic [5:0] ia, logic fl, logic wm, logic [31:0] d,
                               logic [5:0] qa, logic [5:0] qb, logic push, logic [5:0] pa,
                               logic e_we, logic e_qa, logic e_qb, logic e_err);
        vec_t x;
        x.rst = r; x.ie = ie; x.ia = ia; x.fl = fl; x.wm = wm; x.d = d;
        x.qa = qa; x.qb = qb; x.push = push; x.pa = pa;
        x.e_we = e_we; x.e_qa = e_qa; x.e_qb = e_qb; x.e_err = e_err;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s row=%0d got=%h want=%h", nm, row, act, exp);
        end
    endtask

    initial begin
        vec_t r;
        wr_t  ent;
        logic popped;
        logic eh;
        // basic write, addr 5
        tbl.push_back(v(0,1,5,0,1,0,5,6,0,0, 0,0,0,0));
        tbl.push_back(v(0,0,0,0,1,0,5,6,0,0, 0,1,0,0));
        tbl.push_back(v(0,0,0,0,1,0,5,6,0,0, 0,1,0,0));
        tbl.push_back(v(0,0,0,0,0,32'h12345678,5,6,1,5, 0,1,0,0));
        tbl.push_back(v(0,0,0,0,1,0,5,6,0,0, 1,RFB,0,0));
        tbl.push_back(v(0,0,0,0,1,0,5,6,0,0, 0,0,0,0));
        // predicated off, addr 7
        tbl.push_back(v(0,1,7,0,1,0,7,5,0,0, 0,0,0,0));
        tbl.push_back(v(0,0,0,0,1,0,7,5,0,0, 0,1,0,0));
        tbl.push_back(v(0,0,0,0,1,0,7,5,0,0, 0,1,0,0));
        tbl.push_back(v(0,0,0,0,1,32'hDEAD,7,5,0,0, 0,1,0,0));
        tbl.push_back(v(0,0,0,0,1,0,7,5,0,0, 0,0,0,0));
        tbl.push_back(v(0,0,0,0,1,0,7,5,0,0, 0,0,0,0));
        // back-to-back writes to addr 9
        tbl.push_back(v(0,1,9,0,1,0,9,8,0,0, 0,0,0,0));
        tbl.push_back(v(0,1,9,0,1,0,9,8,0,0, 0,1,0,0));
        tbl.push_back(v(0,0,0,0,1,0,9,8,0,0, 0,1,0,0));
        tbl.push_back(v(0,0,0,0,0,32'hA,9,8,1,9, 0,1,0,0));
        tbl.push_back(v(0,0,0,0,0,32'hB,9,8,1,9, 1,1,0,0));
        tbl.push_back(v(0,0,0,0,1,0,9,8,0,0, 1,RFB,0,0));
        tbl.push_back(v(0,0,0,0,1,0,9,8,0,0, 0,0,0,0));
        // flush mid-flight, with a dropped issue in the flush cycle
        tbl.push_back(v(0,1,1,0,1,0,1,3,0,0, 0,0,0,0));
        tbl.push_back(v(0,1,2,0,1,0,1,3,0,0, 0,1,0,0));
        tbl.push_back(v(0,1,3,0,1,0,1,3,0,0, 0,1,0,0));
        tbl.push_back(v(0,1,1,1,0,32'h111,1,3,0,0, 0,1,1,0));
        tbl.push_back(v(0,0,0,0,0,32'h222,1,3,0,0, 0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,32'h333,1,3,0,0, 0,0,0,0));
        tbl.push_back(v(0,0,0,0,1,0,1,3,0,0, 0,0,0,0));
        // idle, then orphan write
        for (int i = 0; i < 10; i++) tbl.push_back(v(0,0,0,0,1,0,10,11,0,0, 0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,32'hBAD,10,11,0,0, 0,0,0,0));
        tbl.push_back(v(0,0,0,0,1,0,10,11,0,0, 0,0,0,1));
        tbl.push_back(v(0,0,0,0,1,0,10,11,0,0, 0,0,0,1));
        // reset mid-operation
        tbl.push_back(v(0,1,4,0,1,0,4,4,0,0, 0,0,0,1));
        tbl.push_back(v(0,0,0,0,1,0,4,4,0,0, 0,1,1,1));
        tbl.push_back(v(1,0,0,0,1,0,4,4,0,0, 0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,32'h77,4,4,0,0, 0,0,0,0));
        tbl.push_back(v(0,0,0,0,1,0,4,4,0,0, 0,0,0,1));
        tbl.push_back(v(0,0,0,0,1,0,4,4,0,0, 0,0,0,1));

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_we", rf_we, 0);
        chk("rst_waddr", rf_waddr, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_err", err_orphan, 0);
        chk("rst_busy", {qa_busy, qb_busy}, 0);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            row = i;
            r = tbl[i];
            @(posedge clk);
            #1;
            rst = r.rst; issue_en = r.ie; issue_addr = r.ia; flush = r.fl; wmask = r.wm; dest = r.d;
            qa_addr = r.qa; qb_addr = r.qb; fwd_addr = r.qa;
            if (r.push) sb.push_back('{a: r.pa, d: r.d});
            @(negedge clk);
            chk("rf_we", rf_we, r.e_we);
            chk("qa_busy", qa_busy, r.e_qa);
            chk("qb_busy", qb_busy, r.e_qb);
            chk("err_orphan", err_orphan, r.e_err);
            if (r.rst) begin
                chk("rst_mid_waddr", rf_waddr, 0);
                chk("rst_mid_wdata", rf_wdata, 0);
            end
            popped = 1'b0;
            ent = '{a: '0, d: '0};
            if (rf_we === 1'b1) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL sb_unexpected row=%0d got addr=%0d data=%h want no write", i, rf_waddr, rf_wdata);
                end else begin
                    ent = sb.pop_front();
                    popped = 1'b1;
                    chk("sb_addr", rf_waddr, ent.a);
                    chk("sb_data", rf_wdata, ent.d);
                end
            end
`ifdef MTSP_WB_FORWARD_EN
            eh = popped & (r.qa == ent.a);
`else
            eh = 1'b0;
`endif
            chk("fwd_hit", fwd_hit, eh);
            chk("fwd_data", fwd_data, eh ? ent.d : 32'h0);
            if (r.rst) begin
                #1;
                rst = 1'b0;
            end
        end
        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
